// File: rtl/sha1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha1_pkg
//  Description : Shared definitions for the SHA-1 compression core.
//                Holds the four round constants, the standard initial
//                vector (for use by the surrounding hash controller), the
//                control FSM state encoding, the working-variable record
//                and a 32-bit rotate-left helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sha1_pkg;

    // Round constants, one per group of 20 rounds.
    localparam logic [31:0] K0 = 32'h5A82_7999;   // rounds  0..19
    localparam logic [31:0] K1 = 32'h6ED9_EBA1;   // rounds 20..39
    localparam logic [31:0] K2 = 32'h8F1B_BCDC;   // rounds 40..59
    localparam logic [31:0] K3 = 32'hCA62_C1D6;   // rounds 60..79

    // Standard initial chaining value H0..H4, H0 in the top word.
    localparam logic [159:0] SHA1_IV =
        160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    // Number of compression rounds; the counter value equal to this marks
    // the finalisation cycle.
    localparam logic [6:0] ROUNDS = 7'd80;

    // Control FSM states.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ROUND = 1'b1
    } sha1_state_e;

    // Working variables A..E, A in the top word (same order as the state).
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_work_t;

    // Rotate a 32-bit word left by n (0 < n < 32).
    function automatic logic [31:0] rotl(input logic [31:0] x,
                                         input int unsigned n);
        rotl = (x << n) | (x >> (32 - n));
    endfunction

endpackage : sha1_pkg
`default_nettype wire

// File: rtl/sha1_round.sv
`default_nettype none
// ============================================================================
//  Module      : sha1_round
//  Description : Combinational single SHA-1 round. Selects the round
//                function f and constant K from the round index, forms
//                T = rotl5(A) + f + E + K + Wt and returns the next working
//                variables {T, A, rotl30(B), C, D}.
//  Ports       : work_i  - current working variables A..E
//                wt_i    - message schedule word for this round
//                t_i     - round index 0..79
//                work_o  - working variables after this round
//  Revision    : 1.0 - initial release
// ============================================================================
module sha1_round
    import sha1_pkg::*;
(
    input  sha1_work_t  work_i,
    input  logic [31:0] wt_i,
    input  logic [6:0]  t_i,
    output sha1_work_t  work_o
);

    logic [31:0] w_f;
    logic [31:0] w_k;
    logic [31:0] w_temp;

    always_comb begin
        w_f = work_i.b ^ work_i.c ^ work_i.d;   // parity, rounds 20..39 / 60..79
        w_k = K3;
        if (t_i < 7'd20) begin
            // Ch: choose C where B is set, D elsewhere.
            w_f = (work_i.b & work_i.c) | (~work_i.b & work_i.d);
            w_k = K0;
        end else if (t_i < 7'd40) begin
            w_k = K1;
        end else if (t_i < 7'd60) begin
            // Maj: bitwise majority of B, C, D.
            w_f = (work_i.b & work_i.c) | (work_i.b & work_i.d)
                | (work_i.c & work_i.d);
            w_k = K2;
        end
        // All additions wrap naturally at 32 bits.
        w_temp = rotl(work_i.a, 5) + w_f + work_i.e + w_k + wt_i;
    end

    assign work_o.a = w_temp;
    assign work_o.b = work_i.a;
    assign work_o.c = rotl(work_i.b, 30);
    assign work_o.d = work_i.c;
    assign work_o.e = work_i.d;

endmodule : sha1_round
`default_nettype wire

// File: rtl/sha1_update.sv
`default_nettype none
// ============================================================================
//  Module      : sha1_update
//  Description : Iterative SHA-1 compression core. Captures one pre-padded
//                512-bit block and a 160-bit chaining state, runs the 80
//                rounds at one round per clock, then adds the working
//                variables back onto the saved chaining state and pulses
//                done. Latency from capture edge to done: 81 cycles;
//                back-to-back throughput: 82 cycles per block.
//  Ports       : clk            - clock, rising edge
//                rst_n          - asynchronous active-low reset
//                start          - compress request, sampled only when idle
//                data_in        - message block, W0 in [511:480]
//                hash_state_in  - chaining state, H0 in [159:128]
//                done           - one-cycle pulse, result valid
//                hash_state_out - updated chaining state, held until the
//                                 next completion
//  Revision    : 1.0 - initial release
// ============================================================================
module sha1_update
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [511:0] data_in,
    input  logic [159:0] hash_state_in,
    output logic         done,
    output logic [159:0] hash_state_out
);

    sha1_state_e  state_q, state_d;
    logic [6:0]   t_q, t_d;
    logic [31:0]  win_q [16];
    logic [31:0]  win_d [16];
    sha1_work_t   work_q, work_d;
    logic [159:0] h_q, h_d;
    logic         done_q, done_d;
    logic [159:0] hout_q, hout_d;

    sha1_work_t   w_round;
    logic [31:0]  w_sched_x;
    logic [31:0]  w_sched_next;

    // ------------------------------------------------------------------
    // Message schedule. The window always holds W[t..t+15], so the head
    // is Wt for every round and the word shifted in at the tail is
    // W[t+16] = rotl1(W[t+13] ^ W[t+8] ^ W[t+2] ^ W[t]). This is the
    // standard recurrence re-indexed, and it keeps the round datapath free
    // of any t<16 multiplexing.
    // ------------------------------------------------------------------
    assign w_sched_x    = win_q[13] ^ win_q[8] ^ win_q[2] ^ win_q[0];
    assign w_sched_next = rotl(w_sched_x, 1);

    sha1_round u_round (
        .work_i (work_q),
        .wt_i   (win_q[0]),
        .t_i    (t_q),
        .work_o (w_round)
    );

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        win_d   = win_q;
        work_d  = work_q;
        h_d     = h_q;
        done_d  = 1'b0;
        hout_d  = hout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = data_in[511 - 32*i -: 32];
                    end
                    h_d     = hash_state_in;
                    work_d  = hash_state_in;
                    t_d     = 7'd0;
                    state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                if (t_q == ROUNDS) begin
                    // Finalisation cycle: fold the working variables back
                    // into the saved chaining state.
                    hout_d  = {h_q[159:128] + work_q.a,
                               h_q[127:96]  + work_q.b,
                               h_q[95:64]   + work_q.c,
                               h_q[63:32]   + work_q.d,
                               h_q[31:0]    + work_q.e};
                    done_d  = 1'b1;
                    t_d     = 7'd0;
                    state_d = ST_IDLE;
                end else begin
                    work_d = w_round;
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i + 1];
                    end
                    win_d[15] = w_sched_next;
                    t_d       = t_q + 7'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                t_d     = 7'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. Reset discards any block in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= 7'd0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
            work_q  <= '0;
            h_q     <= 160'd0;
            done_q  <= 1'b0;
            hout_q  <= 160'd0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
            work_q  <= work_d;
            h_q     <= h_d;
            done_q  <= done_d;
            hout_q  <= hout_d;
        end
    end

    assign done           = done_q;
    assign hash_state_out = hout_q;

endmodule : sha1_update
`default_nettype wire

// File: tb/tb_sha1_update.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha1_update
//  Description : Directed self-checking bench for sha1_update. Uses the
//                FIPS 180 example digests plus a small behavioural SHA-1
//                compression model for non-standard chaining values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha1_update;

    localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_2A    = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_2B    = {480'h0, 32'h000001C0};

    localparam logic [159:0] DIG_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] DIG_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [511:0] data_in;
    logic [159:0] hash_state_in;
    logic         done;
    logic [159:0] hash_state_out;

    int n_cmp = 0;
    int n_err = 0;

    sha1_update dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .data_in        (data_in),
        .hash_state_in  (hash_state_in),
        .done           (done),
        .hash_state_out (hash_state_out)
    );

    always #5 clk = ~clk;

    // Reference compression function with a full 80-word schedule.
    function automatic logic [159:0] sha1_model(input logic [511:0] blk,
                                                input logic [159:0] h);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            tmp  = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {tmp[30:0], tmp[31]};
        end
        a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);            k = 32'h5A827999; end
            else if (i < 40) begin f = b ^ c ^ d;                     k = 32'h6ED9EBA1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d);   k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                     k = 32'hCA62C1D6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check160(input string tag, input logic [159:0] obs,
                            input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a block and pulse start across one capture edge (edge 0).
    task automatic start_block(input logic [511:0] blk, input logic [159:0] h);
        data_in       = blk;
        hash_state_in = h;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    // Counts edges after capture until done is seen; returns limit on timeout.
    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (cycles < limit) begin
            tick();
            cycles++;
            if (done === 1'b1) break;
        end
    endtask

    initial begin
        int cyc;
        int pulses;
        int first;
        logic [159:0] mid;

        rst_n         = 1'b1;
        start         = 1'b0;
        data_in       = '0;
        hash_state_in = '0;

        // Reset state.
        #3 rst_n = 1'b0;
        repeat (2) tick();
        check_int("reset_done", int'(done), 0);
        check160("reset_hout", hash_state_out, 160'h0);
        rst_n = 1'b1;
        tick();

        // "abc" single block.
        start_block(BLK_ABC, IV);
        wait_done(200, cyc);
        check_int("abc_latency", cyc, 81);
        check160("abc_digest", hash_state_out, DIG_ABC);
        tick();
        check_int("abc_done_width", int'(done), 0);
        check160("abc_hold", hash_state_out, DIG_ABC);

        // Empty message.
        start_block(BLK_EMPTY, IV);
        wait_done(200, cyc);
        check_int("empty_latency", cyc, 81);
        check160("empty_digest", hash_state_out, DIG_EMPTY);
        tick();

        // Two-block message, second block started in the done cycle.
        start_block(BLK_2A, IV);
        wait_done(200, cyc);
        check_int("two_blk1_latency", cyc, 81);
        check160("two_blk1_state", hash_state_out, sha1_model(BLK_2A, IV));
        mid = hash_state_out;
        start_block(BLK_2B, mid);
        wait_done(200, cyc);
        check_int("two_blk2_latency", cyc, 81);
        check160("two_digest", hash_state_out, DIG_TWO);
        tick();

        // start held high mid-block with changed inputs: must be ignored.
        start_block(BLK_ABC, IV);
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 200; i++) begin
            if (i == 21) begin
                start         = 1'b1;
                data_in       = ~BLK_ABC;
                hash_state_in = ~IV;
            end
            if (i == 31) start = 1'b0;
            tick();
            if (done === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check_int("ignore_latency", first, 81);
        check_int("ignore_pulses", pulses, 1);
        check160("ignore_digest", hash_state_out, DIG_ABC);
        data_in       = BLK_ABC;
        hash_state_in = IV;

        // Reset at round 40, then restart.
        start_block(BLK_ABC, IV);
        repeat (40) tick();
        rst_n = 1'b0;
        #2;
        check_int("midrst_done", int'(done), 0);
        check160("midrst_hout", hash_state_out, 160'h0);
        repeat (2) tick();
        check160("midrst_hout_held", hash_state_out, 160'h0);
        rst_n = 1'b1;
        tick();
        start_block(BLK_ABC, IV);
        wait_done(200, cyc);
        check_int("restart_latency", cyc, 81);
        check160("restart_digest", hash_state_out, DIG_ABC);
        tick();

        // All ones: exercises wrap-around in every addition.
        start_block({512{1'b1}}, {160{1'b1}});
        wait_done(200, cyc);
        check_int("ones_latency", cyc, 81);
        check160("ones_digest", hash_state_out,
                 sha1_model({512{1'b1}}, {160{1'b1}}));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sha1_update
`default_nettype wire
